uart_cmd_ctrl: RTL and testbench
================================

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 The block SHALL have one clock, CLK, and an asynchronous, active-low reset, RST.
REQ-002 Parameter DATA_WIDTH, default 8: the UART byte width and the register data width.
REQ-003 Parameter ADDR_WIDTH, default 4: the register-file address width.
REQ-004 Parameter RD_TIMEOUT, default 8: the maximum number of cycles to wait for RF_RdData_Valid.
REQ-005 The ports SHALL be as follows:
- CLK  in  1  clock
- RST  in  1  async reset, active low
- RX_P_DATA  in  DATA_WIDTH  byte from the UART receiver
- RX_D_VLD  in  1  one-cycle pulse per received byte
- TX_P_DATA  out  DATA_WIDTH  byte to the UART transmitter
- TX_D_VLD  out  1  one-cycle transmit request
- TX_Busy  in  1  transmitter busy, already synchronized to CLK
- RF_Address  out  ADDR_WIDTH  register address
- RF_WrEn  out  1  one-cycle write strobe
- RF_WrData  out  DATA_WIDTH  write data
- RF_RdEn  out  1  one-cycle read strobe
- RF_RdData  in  DATA_WIDTH  read data
- RF_RdData_Valid  in  1  read data qualifier

Function
REQ-006 The FSM states SHALL be IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT and TX_SEND.
REQ-007 In IDLE:
- RX_D_VLD with byte 0xAA -> WR_ADDR.
- RX_D_VLD with byte 0xBB -> RD_ADDR.
- Any other byte is discarded and the FSM stays in IDLE.
REQ-008 In WR_ADDR, on RX_D_VLD, the FSM SHALL latch RX_P_DATA[ADDR_WIDTH-1:0] as the address and go to WR_DATA.
REQ-009 In WR_DATA, on RX_D_VLD, the block SHALL drive RF_WrData = byte and RF_WrEn = 1 on the next cycle for exactly one cycle, then go to IDLE.
REQ-010 In RD_ADDR, on RX_D_VLD, the block SHALL latch the address, pulse RF_RdEn for one cycle on the next cycle, and go to RD_WAIT.
REQ-011 In RD_WAIT, on RF_RdData_Valid, the block SHALL latch RF_RdData into the reply register and go to TX_SEND.
REQ-012 In RD_WAIT, if RD_TIMEOUT cycles elapse after RF_RdEn without RF_RdData_Valid, the block SHALL load reply 0xEE and go to TX_SEND.
REQ-013 In TX_SEND, when TX_Busy = 0, the block SHALL present TX_P_DATA = reply and assert TX_D_VLD for exactly one cycle, then go to IDLE.
REQ-014 In TX_SEND, while TX_Busy = 1, the block SHALL hold the state with TX_D_VLD = 0.
REQ-015 RX_D_VLD pulses received in RD_WAIT or TX_SEND SHALL be dropped; they SHALL NOT be queued and SHALL NOT be interpreted as commands.
REQ-016 If RF_RdData_Valid arrives in the same cycle as the timeout, the read data SHALL take precedence over 0xEE.
REQ-017 All outputs SHALL be registered.
REQ-018 RF_Address SHALL hold its last latched value between commands.
REQ-019 TX_P_DATA SHALL hold the reply value while TX_D_VLD is low.
REQ-020 The timeout counter SHALL be wide enough for RD_TIMEOUT, SHALL clear on entry to RD_WAIT, and SHALL NOT wrap.
REQ-021 RF_WrEn and RF_RdEn SHALL never be asserted in the same cycle.

Reset
REQ-022 When RST = 0, the block SHALL immediately (asynchronously) apply the following:
- State = IDLE.
- TX_D_VLD, RF_WrEn and RF_RdEn = 0.
- TX_P_DATA, RF_WrData, RF_Address, reply register and timeout counter = 0.
REQ-023 A reset asserted mid-command SHALL abandon the command, with no strobe generated afterwards.
REQ-024 The first command after reset release SHALL be accepted in the first cycle in which RST = 1.

Structure
REQ-025 A shared package SHALL hold:
- the state enumeration;
- the command constants CMD_WR = 0xAA and CMD_RD = 0xBB;
- the timeout reply constant RD_ERR = 0xEE.
REQ-026 The timeout counter SHALL be implemented inline, with no sub-modules.

Verification
REQ-027 Write: bytes 0xAA, 0x05, 0x3C -> one cycle after the third RX_D_VLD, RF_WrEn = 1 for 1 cycle with RF_Address = 5 and RF_WrData = 0x3C.
REQ-028 Read: bytes 0xBB, 0x02; RF_RdData = 0x7E valid 3 cycles after RF_RdEn; TX_Busy = 0 -> TX_D_VLD for 1 cycle with TX_P_DATA = 0x7E, one cycle after the valid.
REQ-029 Timeout: bytes 0xBB, 0x09 and no RF_RdData_Valid -> 8 cycles after RF_RdEn, TX_D_VLD with TX_P_DATA = 0xEE.
REQ-030 Busy back-pressure: read completes with TX_Busy = 1 for 20 cycles -> TX_D_VLD stays 0; it asserts exactly once, the cycle after TX_Busy falls.
REQ-031 Junk and drops:
- Byte 0x11 in IDLE -> no strobes.
- Byte 0xAA sent during RD_WAIT -> dropped.
- A subsequent 0xAA, 0x01, 0x02 -> a normal write.
REQ-032 Reset mid-write: RST low after 0xAA, 0x04 -> no RF_WrEn; after release, bytes 0xBB, 0x04 -> a normal read.

Source files
------------

// File: rtl/uart_cmd_ctrl_pkg.sv
// uart_cmd_ctrl_pkg: shared state encoding and command/reply byte constants
package uart_cmd_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND} state_t;
    localparam logic [7:0] CMD_WR = 8'hAA;
    localparam logic [7:0] CMD_RD = 8'hBB;
    localparam logic [7:0] RD_ERR = 8'hEE;
endpackage

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: decodes UART byte commands into register-file writes/reads
// and returns read data (or a timeout marker) over the UART transmitter.
module uart_cmd_ctrl
    import uart_cmd_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int RD_TIMEOUT = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  TX_Busy,
    output logic [ADDR_WIDTH-1:0] RF_Address,
    output logic                  RF_WrEn,
    output logic [DATA_WIDTH-1:0] RF_WrData,
    output logic                  RF_RdEn,
    input  logic [DATA_WIDTH-1:0] RF_RdData,
    input  logic                  RF_RdData_Valid
);
    localparam int CW = $clog2(RD_TIMEOUT + 1);

    state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic timeout, rd_done;

    assign timeout = cnt == CW'(RD_TIMEOUT - 1);
    assign rd_done = state == RD_WAIT && (RF_RdData_Valid || timeout);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = !RX_D_VLD ? IDLE :
                                 RX_P_DATA == DATA_WIDTH'(CMD_WR) ? WR_ADDR :
                                 RX_P_DATA == DATA_WIDTH'(CMD_RD) ? RD_ADDR : IDLE;
            WR_ADDR: state_nxt = RX_D_VLD ? WR_DATA : WR_ADDR;
            WR_DATA: state_nxt = RX_D_VLD ? IDLE : WR_DATA;
            RD_ADDR: state_nxt = RX_D_VLD ? RD_WAIT : RD_ADDR;
            RD_WAIT: state_nxt = rd_done ? TX_SEND : RD_WAIT;
            TX_SEND: state_nxt = TX_D_VLD ? IDLE : TX_SEND;
            default: state_nxt = IDLE;
        endcase
    end

    // TX_P_DATA doubles as the reply register; the send fires on entry to
    // TX_SEND when the transmitter is free, otherwise once it frees up.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            TX_P_DATA  <= '0;
            TX_D_VLD   <= 1'b0;
            RF_Address <= '0;
            RF_WrEn    <= 1'b0;
            RF_WrData  <= '0;
            RF_RdEn    <= 1'b0;
            cnt        <= '0;
        end else begin
            RF_WrEn <= state == WR_DATA && RX_D_VLD;
            RF_RdEn <= state == RD_ADDR && RX_D_VLD;
            if ((state == WR_ADDR || state == RD_ADDR) && RX_D_VLD)
                RF_Address <= RX_P_DATA[ADDR_WIDTH-1:0];
            if (state == WR_DATA && RX_D_VLD)
                RF_WrData <= RX_P_DATA;
            cnt <= state != RD_WAIT ? '0 : cnt < CW'(RD_TIMEOUT) ? cnt + 1'b1 : cnt;
            if (rd_done)
                TX_P_DATA <= RF_RdData_Valid ? RF_RdData : DATA_WIDTH'(RD_ERR);
            TX_D_VLD <= rd_done ? !TX_Busy : state == TX_SEND && !TX_D_VLD && !TX_Busy;
        end
    end
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: randomized scoreboard bench; stimulus tasks predict each
// strobe (kind, cycle, fields) and a negedge monitor pops and compares.
module tb_uart_cmd_ctrl;
    localparam int DW = 8, AW = 4, TO = 8;

    logic          CLK = 1'b0, RST = 1'b0;
    logic [DW-1:0] RX_P_DATA = '0, TX_P_DATA, RF_WrData, RF_RdData = '0;
    logic          RX_D_VLD = 1'b0, TX_D_VLD, TX_Busy = 1'b0;
    logic [AW-1:0] RF_Address;
    logic          RF_WrEn, RF_RdEn, RF_RdData_Valid = 1'b0;

    typedef struct {int kind; int addr; int data; int cyc;} ev_t;
    ev_t q[$];
    int cyc = 0, checks = 0, failures = 0;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_reply = '0;

    uart_cmd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_Busy(TX_Busy),
        .RF_Address(RF_Address), .RF_WrEn(RF_WrEn), .RF_WrData(RF_WrData),
        .RF_RdEn(RF_RdEn), .RF_RdData(RF_RdData), .RF_RdData_Valid(RF_RdData_Valid)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest predicted event.
    always @(negedge CLK) if (RST) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            chk("missed_event_kind", 32'hFFFF, q[0].kind);
            void'(q.pop_front());
        end
        if (RF_WrEn || RF_RdEn || TX_D_VLD) begin
            int kind;
            kind = RF_WrEn ? 0 : RF_RdEn ? 1 : 2;
            chk("strobe_overlap", {31'd0, RF_WrEn & RF_RdEn}, 0);
            if (q.size() == 0) chk("unexpected_strobe_kind", kind, 32'hFFFF);
            else begin
                ev_t e;
                e = q.pop_front();
                chk("event_kind", kind, e.kind);
                chk("event_cycle", cyc, e.cyc);
                if (kind == 0) begin
                    chk("wr_addr", RF_Address, e.addr);
                    chk("wr_data", RF_WrData, e.data);
                end else if (kind == 1) chk("rd_addr", RF_Address, e.addr);
                else chk("tx_data", TX_P_DATA, e.data);
            end
        end
    end

    task automatic step();
        @(posedge CLK); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b; RX_D_VLD = 1'b1;
        step();
        RX_D_VLD = 1'b0; RX_P_DATA = 8'($urandom);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        send_byte(8'hAA);
        send_byte(a);
        q.push_back('{0, int'(a) % 16, int'(d), cyc + 1});
        send_byte(d);
        last_addr = a[3:0];
    endtask

    // d = cycles after RF_RdEn at which valid is driven (>=TO means never in time)
    task automatic do_read(input logic [7:0] a, input int d, input int busy_n,
                           input logic [7:0] rdv, input bit drop);
        int t0, r, tx;
        logic [7:0] rep;
        send_byte(8'hBB);
        t0 = cyc + 1;
        q.push_back('{1, int'(a) % 16, 0, t0});
        send_byte(a);
        r   = d <= TO - 1 ? t0 + d + 1 : t0 + TO;
        rep = d <= TO - 1 ? rdv : 8'hEE;
        tx  = r > t0 + busy_n + 1 ? r : t0 + busy_n + 1;
        q.push_back('{2, 0, int'(rep), tx});
        while (cyc <= tx) begin
            TX_Busy = cyc < t0 + busy_n;
            RF_RdData_Valid = cyc == t0 + d;
            RF_RdData = cyc == t0 + d ? rdv : 8'($urandom);
            RX_D_VLD = drop && cyc == t0 + 1;
            RX_P_DATA = 8'hAA;
            step();
        end
        TX_Busy = 1'b0; RF_RdData_Valid = 1'b0; RX_D_VLD = 1'b0;
        last_addr = a[3:0]; last_reply = rep;
    endtask

    task automatic do_junk(input logic [7:0] j);
        send_byte(j);
        step();
        chk("addr_hold", RF_Address, last_addr);
        chk("reply_hold", TX_P_DATA, last_reply);
        chk("tx_idle", TX_D_VLD, 0);
    endtask

    task automatic check_reset();
        chk("rst_tx_data", TX_P_DATA, 0);
        chk("rst_tx_vld", TX_D_VLD, 0);
        chk("rst_addr", RF_Address, 0);
        chk("rst_wr_en", RF_WrEn, 0);
        chk("rst_wr_data", RF_WrData, 0);
        chk("rst_rd_en", RF_RdEn, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        #1 check_reset();
        step(); step();
        RST = 1'b1;
        do_write(8'h05, 8'h3C);
        do_read(8'h02, 3, 0, 8'h7E, 0);
        do_read(8'h09, 99, 0, 8'h00, 0);
        do_read(8'h03, 3, 20, 8'h5A, 0);
        do_read(8'h06, TO - 1, 0, 8'hC3, 0);
        do_junk(8'h11);
        do_read(8'h07, 5, 0, 8'h81, 1);
        do_write(8'h01, 8'h02);
        do_junk(8'h42);
        send_byte(8'hAA);
        send_byte(8'h04);
        RST = 1'b0;
        #1 check_reset();
        step(); step();
        RST = 1'b1;
        last_addr = '0; last_reply = '0;
        do_read(8'h04, 2, 0, 8'h99, 0);
        for (int i = 0; i < 60; i++) begin
            int op;
            logic [7:0] j;
            op = $urandom_range(0, 2);
            if (op == 0) do_write(8'($urandom), 8'($urandom));
            else if (op == 1)
                do_read(8'($urandom), $urandom_range(0, 10),
                        $urandom_range(0, 3) == 0 ? $urandom_range(1, 12) : 0,
                        8'($urandom), 1'($urandom));
            else begin
                do j = 8'($urandom); while (j == 8'hAA || j == 8'hBB);
                do_junk(j);
            end
            repeat ($urandom_range(0, 2)) step();
        end
        repeat (5) step();
        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
